mod53_residue_accumulator: RTL and testbench
============================================

# mod53_residue_accumulator

Sequential accumulator that consumes the 6-bit residue words produced by the mod-53 LUT stages (one residue per chunk of a wide operand) and folds them into a single residue modulo 53. It sits directly downstream of the per-chunk LUT bank: each accepted beat carries one chunk residue, and a frame ends with `in_last`. The block emits the final residue with a valid/ready handshake toward the next modular-arithmetic stage.

## Interface
Parameters:
- `MOD`, 53, modulus; fixed for this instance, and the arithmetic below is sized for it.
- `CNT_W`, 5, width of the beat counter reported per frame.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream residue beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_data` input 6: chunk residue; nominally 0..52.
- `in_last` input 1: marks the final beat of a frame.
- `out_valid` output 1: frame result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output 6: (sum of frame beats) mod 53, range 0..52.
- `out_count` output CNT_W: number of beats in the frame, saturating at 31.
- `err` output 1: sticky out-of-range flag; only functional with `MOD53_RANGE_CHECK_EN`.

## Operation
- States: ACC and HOLD. Reset state is ACC.
- ACC:
  - `in_ready`=1.
  - On each beat where `in_valid`&`in_ready`: `acc_next = acc + r`, where `r` is the beat value (reduced as described in Configuration).
  - The 7-bit sum is at most 104. If the sum ≥53, subtract 53. The result is always 0..52.
  - On the same beat, `cnt` increments and saturates at 31.
- Beat with `in_last`=1:
  - Load the final reduced sum into `out_data`.
  - Load `cnt+1` (saturated) into `out_count`.
  - Assert `out_valid`, go to HOLD.
  - Clear `acc` and `cnt` to 0.
- HOLD:
  - `in_ready`=0.
  - `out_data` and `out_count` held stable.
  - On `out_valid`&`out_ready`: deassert `out_valid`, return to ACC.
- `in_ready` is a pure function of state (registered); there is no combinational path from `out_ready` to `in_ready`.
- A single-beat frame (`in_last` on the first beat) yields `out_data` = reduced `in_data` and `out_count`=1.
- An empty frame is not representable. Every frame has at least one beat.
- Reset values:
  - `in_ready`=1 (after reset deasserts).
  - `out_valid`=0, `out_data`=0, `out_count`=0, `err`=0.
  - `acc`=0, `cnt`=0, state ACC.
- Reset mid-frame or in HOLD: the partial sum and any pending result are discarded immediately (asynchronous). No output beat is produced.

## Timing
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat. The result is visible the cycle after the last beat is presented.
- Throughput:
  - One beat per cycle within a frame.
  - At least one bubble cycle between frames: the HOLD→ACC transition takes the cycle in which the output handshake completes.
  - The first beat of the next frame is accepted no earlier than the cycle after `out_valid` falls.
- `in_data` and `in_last` are sampled only when `in_valid`&`in_ready`. Otherwise they are don't-care.
- `out_valid`, once high, stays high until handshaken. Output values are stable throughout.

## Configuration
- `MOD53_RANGE_CHECK_EN` defined:
  - Each beat is pre-reduced: `r = (in_data ≥ 53) ? in_data − 53 : in_data`.
  - Any accepted beat with `in_data` ≥53 sets `err`=1. `err` is sticky and cleared only by `rst_n`.
- Not defined:
  - `r = in_data` with no comparison; inputs ≥53 give an undefined result.
  - `err` is tied to 0.

## Test plan
- Frame 52, 52, 52 (last on third), `out_ready`=1 → `out_data`=50, `out_count`=3; `out_valid` high for exactly 1 cycle; `in_ready` low for that cycle.
- Single beat 0 with `in_last` → `out_data`=0, `out_count`=1. Then frame 1, 52 → `out_data`=0, `out_count`=2 (wrap to zero).
- Backpressure: frame 10, 20 with `out_ready`=0 for 5 cycles → `out_data`=30 stable, `in_ready`=0 throughout. Next frame's beats are accepted only after the handshake.
- 40 beats of value 1, last on the 40th → `out_data`=40, `out_count`=31 (saturated).
- Assert `rst_n`=0 after 2 beats of a frame (e.g. 30, 30), then send the frame 5 (last) → `out_data`=5, `out_count`=1; no stale result is emitted.
- With `MOD53_RANGE_CHECK_EN`: frame 60, 50 (last) → `out_data`=4 (7+50=57−53), `err`=1, and `err` stays 1 across later clean frames. Without the macro, `err` stays 0.

Source files
------------

// File: rtl/mod53_residue_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : mod53_residue_accumulator_if
// Description : Residue beat input and frame result output handshakes for the
//               mod-53 residue accumulator.
// Revision    : 1.0
// ============================================================================
interface mod53_residue_accumulator_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_data;
    logic [CNT_W-1:0] out_count;
    logic             err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, err
    );
endinterface
`default_nettype wire

// File: rtl/mod53_residue_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mod53_residue_accumulator
// Description : Folds a frame of 6-bit chunk residues into one residue mod 53
//               and reports it with the frame's saturating beat count.
//               Optional input range check: MOD53_RANGE_CHECK_EN.
// Revision    : 1.0
// ============================================================================
module mod53_residue_accumulator #(
    parameter int MOD   = 53,
    parameter int CNT_W = 5
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    mod53_residue_accumulator_if.slave  s_bus
);
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [6:0]       c_MOD7    = 7'(MOD);
    localparam logic [5:0]       c_MOD6    = 6'(MOD);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [5:0]       r_acc;
    logic [5:0]       w_acc_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [5:0]       r_out_data;
    logic [5:0]       w_out_data_next;
    logic [CNT_W-1:0] r_out_count;
    logic [CNT_W-1:0] w_out_count_next;

    logic             w_accept;
    logic [5:0]       w_beat;
    logic [6:0]       w_sum;
    logic [5:0]       w_sum_red;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_accept = s_bus.in_valid & (r_state == ST_ACC);

`ifdef MOD53_RANGE_CHECK_EN
    logic w_oor;
    logic r_err;

    assign w_oor  = (s_bus.in_data >= c_MOD6);
    assign w_beat = w_oor ? (s_bus.in_data - c_MOD6) : s_bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_oor) begin
            r_err <= 1'b1;
        end
    end

    assign s_bus.err = r_err;
`else
    assign w_beat    = s_bus.in_data;
    assign s_bus.err = 1'b0;
`endif

    // Sum never exceeds 104, so one conditional subtract is enough; the low six
    // bits of (sum - MOD) equal the full difference because it stays below 64.
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_beat};
    assign w_sum_red = (w_sum >= c_MOD7) ? (w_sum[5:0] - c_MOD6) : w_sum[5:0];
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        w_out_data_next  = r_out_data;
        w_out_count_next = r_out_count;
        case (r_state)
            ST_ACC: begin
                if (w_accept) begin
                    if (s_bus.in_last) begin
                        w_out_data_next  = w_sum_red;
                        w_out_count_next = w_cnt_inc;
                        w_acc_next       = '0;
                        w_cnt_next       = '0;
                        w_state_next     = ST_HOLD;
                    end else begin
                        w_acc_next       = w_sum_red;
                        w_cnt_next       = w_cnt_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (s_bus.out_ready) begin
                    w_state_next = ST_ACC;
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_out_data  <= w_out_data_next;
            r_out_count <= w_out_count_next;
        end
    end

    // Both handshake flags decode the state register only, so out_ready never
    // reaches in_ready combinationally.
    assign s_bus.in_ready  = (r_state == ST_ACC);
    assign s_bus.out_valid = (r_state == ST_HOLD);
    assign s_bus.out_data  = r_out_data;
    assign s_bus.out_count = r_out_count;
endmodule
`default_nettype wire

// File: tb/tb_mod53_residue_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod53_residue_accumulator
// Description : Directed self-checking bench with a result scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_mod53_residue_accumulator;
    typedef struct {
        logic [5:0] d;
        logic [4:0] c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    int   m_sum;
    int   m_n;

    mod53_residue_accumulator_if #(.CNT_W(5)) bus ();

    mod53_residue_accumulator #(.MOD(53), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result monitor: every completed output handshake must match the oldest
    // expected frame result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("unexpected_output", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.d);
                chk("out_count", bus.out_count, e.c);
            end
        end
    end

    task automatic send_beat(input int d, input bit last);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 6'(d);
        bus.in_last  = last;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("accept_timeout", acc, 1);
        if (acc) begin
            m_sum = (m_sum + d) % 53;
            m_n++;
            if (last) begin
                exp_t e;
                e.d = 6'(m_sum);
                e.c = 5'((m_n > 31) ? 31 : m_n);
                sb.push_back(e);
                m_sum = 0;
                m_n   = 0;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        m_sum         = 0;
        m_n           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_err", bus.err, 0);

        // 52+52+52 = 156 = 2*53 + 50; result held exactly one cycle
        send_beat(52, 0);
        send_beat(52, 0);
        send_beat(52, 1);
        chk("f1_out_valid_hi", bus.out_valid, 1);
        chk("f1_in_ready_lo", bus.in_ready, 0);
        chk("f1_value", bus.out_data, 50);
        @(posedge clk);
        #1;
        chk("f1_out_valid_lo", bus.out_valid, 0);
        chk("f1_in_ready_hi", bus.in_ready, 1);
        wait_drain();

        send_beat(0, 1);
        send_beat(1, 0);
        send_beat(52, 1);
        wait_drain();

        // Backpressure: result must stay put and no beat may be taken
        bus.out_ready = 1'b0;
        send_beat(10, 0);
        send_beat(20, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd7;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_data", bus.out_data, 30);
            chk("bp_out_count", bus.out_count, 2);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send_beat(7, 1);
        wait_drain();

        for (int i = 0; i < 40; i++) begin
            send_beat(1, (i == 39));
        end
        wait_drain();

        // Asynchronous reset mid-frame discards the partial sum
        send_beat(30, 0);
        send_beat(30, 0);
        #2;
        rst_n = 1'b0;
        m_sum = 0;
        m_n   = 0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(5, 1);
        wait_drain();

`ifdef MOD53_RANGE_CHECK_EN
        send_beat(60, 0);
        send_beat(50, 1);
        wait_drain();
        chk("err_set", bus.err, 1);
        send_beat(3, 0);
        send_beat(4, 1);
        wait_drain();
        chk("err_sticky", bus.err, 1);
`else
        send_beat(50, 0);
        send_beat(6, 1);
        wait_drain();
        chk("err_tied_low", bus.err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
